// File: rtl/seg7_scan_capture.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_capture
// Purpose  : Receive-side monitor for a multiplexed, active-low 7-segment
//            display bus. Rebuilds the hex value, decimal point and blank
//            state of every digit, and raises sticky error flags for stable
//            segment patterns that are not hex glyphs.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk    in   1          single clock domain
//   rst    in   1          asynchronous active-high reset
//   clr    in   1          synchronous clear of VALID, ERR and seen mask
//   AN     in   DIGITS     anode enables, active-low, one-hot-low selects digit
//   SEG    in   8          segments, active-low, [0]=a .. [6]=g, [7]=point
//   HEX    out  4*DIGITS   captured value, digit i at HEX[4i+3:4i]
//   DP     out  DIGITS     decimal point lit for digit i
//   BLANK  out  DIGITS     digit i captured with segments a-g all off
//   VALID  out  DIGITS     digit i had a good or blank capture since rst/clr
//   ERR    out  DIGITS     sticky: digit i showed a stable non-hex pattern
//   FRAME  out  1          one-cycle pulse once every digit has been captured
// ============================================================================
module seg7_scan_capture #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic [DIGITS-1:0]     AN,
    input  logic [7:0]            SEG,
    output logic [4*DIGITS-1:0]   HEX,
    output logic [DIGITS-1:0]     DP,
    output logic [DIGITS-1:0]     BLANK,
    output logic [DIGITS-1:0]     VALID,
    output logic [DIGITS-1:0]     ERR,
    output logic                  FRAME
);

    localparam logic [7:0]        c_STABLE = 8'(STABLE_CYCLES);
    localparam logic [7:0]        c_SAT    = 8'hFF;
    localparam logic [DIGITS-1:0] c_ONE    = DIGITS'(1);
    localparam logic [DIGITS-1:0] c_ALL    = {DIGITS{1'b1}};

    // Two-flop synchronizers plus the previous synchronized sample.
    logic [DIGITS-1:0] r_anMeta, r_anSync, r_anPrev;
    logic [7:0]        r_segMeta, r_segSync, r_segPrev;
    logic [7:0]        r_stable;

    // Capture stage: pattern that just completed its stable interval.
    logic              r_capFire;
    logic [DIGITS-1:0] r_capSel;
    logic [7:0]        r_capSeg;

    logic [4*DIGITS-1:0] r_hex;
    logic [DIGITS-1:0]   r_dp, r_blank, r_valid, r_err, r_seen;
    logic                r_frame;

    logic [DIGITS-1:0] w_anSel;
    logic              w_oneHot;
    logic              w_restart;
    logic [7:0]        w_countNext;
    logic              w_fire;
    logic [6:0]        w_pat;
    logic              w_glyphOk;
    logic              w_isBlank;
    logic [3:0]        w_glyphVal;
    logic [DIGITS-1:0] w_capBits, w_goodBits, w_badBits;
    logic [DIGITS-1:0] w_seenSet;
    logic              w_frameNow;

    // ------------------------------------------------------------------
    // Stability tracking on the synchronized bus
    // ------------------------------------------------------------------
    always_comb begin
        w_anSel     = ~r_anSync;
        w_oneHot    = (w_anSel != '0) && ((w_anSel & (w_anSel - c_ONE)) == '0);
        w_restart   = (r_anSync != r_anPrev) || (r_segSync != r_segPrev) || !w_oneHot;
        w_countNext = w_restart ? 8'd1 : ((r_stable == c_SAT) ? c_SAT : r_stable + 8'd1);
        // Fire only on the transition into STABLE_CYCLES; a saturated counter
        // sitting at 255 must not fire again every cycle.
        w_fire      = w_oneHot && (w_countNext == c_STABLE) &&
                      (w_restart || (r_stable != c_SAT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_anMeta  <= c_ALL;
            r_anSync  <= c_ALL;
            r_anPrev  <= c_ALL;
            r_segMeta <= 8'hFF;
            r_segSync <= 8'hFF;
            r_segPrev <= 8'hFF;
            r_stable  <= 8'd0;
            r_capFire <= 1'b0;
            r_capSel  <= '0;
            r_capSeg  <= 8'hFF;
        end else begin
            r_anMeta  <= AN;
            r_anSync  <= r_anMeta;
            r_anPrev  <= r_anSync;
            r_segMeta <= SEG;
            r_segSync <= r_segMeta;
            r_segPrev <= r_segSync;
            r_stable  <= w_countNext;
            r_capFire <= w_fire;
            r_capSel  <= w_anSel;
            r_capSeg  <= r_segSync;
        end
    end

    // ------------------------------------------------------------------
    // Glyph decode of the captured pattern (gfedcba, active-high)
    // ------------------------------------------------------------------
    always_comb begin
        w_pat      = ~r_capSeg[6:0];
        w_glyphOk  = 1'b1;
        w_glyphVal = 4'h0;
        w_isBlank  = (w_pat == 7'h00);
        case (w_pat)
            7'h3F: w_glyphVal = 4'h0;
            7'h06: w_glyphVal = 4'h1;
            7'h5B: w_glyphVal = 4'h2;
            7'h4F: w_glyphVal = 4'h3;
            7'h66: w_glyphVal = 4'h4;
            7'h6D: w_glyphVal = 4'h5;
            7'h7D: w_glyphVal = 4'h6;
            7'h07: w_glyphVal = 4'h7;
            7'h7F: w_glyphVal = 4'h8;
            7'h6F: w_glyphVal = 4'h9;
            7'h77: w_glyphVal = 4'hA;
            7'h7C: w_glyphVal = 4'hB;
            7'h39: w_glyphVal = 4'hC;
            7'h5E: w_glyphVal = 4'hD;
            7'h79: w_glyphVal = 4'hE;
            7'h71: w_glyphVal = 4'hF;
            default: w_glyphOk = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Per-digit update, seen mask and frame pulse
    // ------------------------------------------------------------------
    always_comb begin
        w_capBits  = r_capFire ? r_capSel : '0;
        w_goodBits = (w_glyphOk || w_isBlank) ? w_capBits : '0;
        w_badBits  = (w_glyphOk || w_isBlank) ? '0 : w_capBits;
        // clr empties the mask first so a simultaneous capture still lands.
        w_seenSet  = (clr ? '0 : r_seen) | w_capBits;
        w_frameNow = (w_seenSet == c_ALL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hex   <= '0;
            r_dp    <= '0;
            r_blank <= c_ALL;
            r_valid <= '0;
            r_err   <= '0;
            r_seen  <= '0;
            r_frame <= 1'b0;
        end else begin
            r_valid <= (clr ? '0 : r_valid) | w_goodBits;
            r_err   <= (clr ? '0 : r_err) | w_badBits;
            r_seen  <= w_frameNow ? '0 : w_seenSet;
            r_frame <= w_frameNow;
            for (int i = 0; i < DIGITS; i++) begin
                if (w_capBits[i]) begin
                    r_dp[i] <= ~r_capSeg[7];
                end
                if (w_goodBits[i]) begin
                    r_hex[4*i +: 4] <= w_isBlank ? 4'h0 : w_glyphVal;
                    r_blank[i]      <= w_isBlank;
                end
            end
        end
    end

    assign HEX   = r_hex;
    assign DP    = r_dp;
    assign BLANK = r_blank;
    assign VALID = r_valid;
    assign ERR   = r_err;
    assign FRAME = r_frame;

endmodule
`default_nettype wire

// File: doc/seg7_scan_capture.md
# seg7_scan_capture

Receive-side counterpart of the hex-to-7-segment decoder. It samples a multiplexed, active-low 7-segment display bus (anodes plus segments a–g and point) and rebuilds the hex value, decimal-point state and blank state of every digit. It then raises sticky error flags for segment patterns that are not valid hex glyphs. It sits beside the display driver as a self-check and loopback monitor, and its outputs go to on-board LEDs and the verification bench.

## Interface
Parameters:
- DIGITS, 4: number of multiplexed digits (1–8).
- STABLE_CYCLES, 4: number of consecutive identical synchronized samples required before a capture (1–255).

Ports:
- clk  in  1  single clock; all state is in this domain.
- rst  in  1  reset, asynchronous and active-high.
- clr  in  1  synchronous clear of VALID, ERR and the frame-seen mask.
- AN  in  DIGITS  anode enables, active-low; exactly one bit low selects a digit.
- SEG  in  8  segments, active-low: SEG[0]=a … SEG[6]=g, SEG[7]=p.
- HEX  out  4*DIGITS  captured value; digit i is at HEX[4i+3:4i].
- DP  out  DIGITS  decimal point lit for digit i.
- BLANK  out  DIGITS  digit i was captured with all of segments a–g off.
- VALID  out  DIGITS  digit i has had at least one good or blank capture since reset or clr.
- ERR  out  DIGITS  sticky flag: digit i presented a stable, non-hex, non-blank pattern.
- FRAME  out  1  one-cycle pulse when every digit has been captured since the last FRAME.

## Operation
- AN and SEG each pass through a 2-flop synchronizer. All later logic uses only the synchronized copies.
- The stability counter is 8 bits and saturates. It resets to 1 whenever the synchronized {AN,SEG} differs from the previous cycle.
  - It also resets when AN is not exactly one-hot-low (all high, or more than one low).
  - While AN is not one-hot-low, no capture occurs.
- A capture fires once, on the cycle the counter reaches STABLE_CYCLES. There is no recapture until {AN,SEG} changes.
- Glyph decode uses pattern P = ~SEG[6:0] in gfedcba order:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- Capture to digit i, where i is the index of the low AN bit:
  - P matches a glyph: HEX[i] = the glyph value, BLANK[i]=0, VALID[i]=1.
  - P=00: BLANK[i]=1, HEX[i]=0, VALID[i]=1.
  - Any other P: ERR[i]=1; HEX[i], BLANK[i] and VALID[i] are unchanged.
  - In all three cases DP[i] = ~SEG[7], and bit i is set in the seen mask.
- When the seen mask is all ones, FRAME pulses for one cycle and the mask clears in the same cycle. A capture in that same cycle is recorded in the freshly cleared mask.
- clr clears VALID, ERR and the seen mask and leaves HEX, DP and BLANK unchanged.
  - If clr and a capture occur in the same cycle, the capture wins for its own bits.

## Timing
- Reset values:
  - HEX, DP, VALID, ERR, FRAME = 0.
  - BLANK = all ones.
  - Synchronizers = AN all high, SEG all high.
  - Stability counter = 0, seen mask = 0.
- Latency: with inputs held constant from rising edge k onward, the outputs show the capture after edge k+STABLE_CYCLES+2.
- FRAME asserts in the same cycle that the final digit's capture becomes visible.
- A stable interval shorter than STABLE_CYCLES samples produces no capture and no ERR.
- With STABLE_CYCLES=1, every change that lasts one synchronized sample is captured.
- Asserting rst mid-capture returns all state to reset values immediately.
  - After release, the next capture needs a full new stable interval, because the synchronizers restart from all high.

## Test plan
- Reset: assert rst for 3 cycles → HEX=0000, BLANK=1111, VALID=ERR=DP=0, FRAME=0, with no X on any output.
- Single digit (DIGITS=4, STABLE_CYCLES=4): hold AN=1110, SEG=~8'hDB → HEX[3:0]=2 and DP[0]=1 exactly 6 edges after the first sample, VALID=0001. Raise SEG after 3 cycles in a rerun → no update.
- Full scan: cycle AN through 1110/1101/1011/0111 with glyphs 1, A, blank, F, holding each for 8 cycles → HEX=F0A1, BLANK=0100, VALID=1111, exactly one FRAME pulse per full scan.
- Invalid glyph: AN=1101, SEG=~8'h49 held for 8 cycles → ERR=0010 and HEX unchanged. Then pulse clr → ERR=0000, VALID=0000.
- Bad anodes: hold AN=1100 and AN=1111 for 20 cycles each with a valid SEG → no output changes and no FRAME.
- Reset mid-capture: assert rst 2 cycles into a stable interval → reset values. After release, the capture occurs STABLE_CYCLES+2 edges after the inputs are first sampled.
